// File: rtl/bilin_phase_gen_pkg.sv
// Shared constants and FSM state type for the bilinear scaler phase generator.
package bilin_pkg;
  localparam int          FRAC_W   = 8;
  localparam logic [15:0] STEP_MIN = 16'h0020;
  localparam logic [15:0] STEP_MAX = 16'h01FF;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
endpackage

// File: rtl/bilin_phase_gen_if.sv
// Line config, pixel input handshake and interpolation-pair output bundle.
interface bilin_phase_gen_if #(
  parameter int W_CNT  = 12,
  parameter int FRAC_W = 8
);
  logic [15:0]       step_i;
  logic [W_CNT-1:0]  in_width_i;
  logic [W_CNT-1:0]  out_width_i;
  logic              sol_i;
  logic [7:0]        pix_i;
  logic              pix_vld_i;
  logic              pix_rdy_o;
  logic [7:0]        din1_o;
  logic [7:0]        din2_o;
  logic [FRAC_W-1:0] kremain_o;
  logic              out_vld_o;
  logic              eol_o;
  logic              busy_o;

  modport master (
    output step_i, in_width_i, out_width_i, sol_i, pix_i, pix_vld_i,
    input  pix_rdy_o, din1_o, din2_o, kremain_o, out_vld_o, eol_o, busy_o
  );
  modport slave (
    input  step_i, in_width_i, out_width_i, sol_i, pix_i, pix_vld_i,
    output pix_rdy_o, din1_o, din2_o, kremain_o, out_vld_o, eol_o, busy_o
  );
endinterface

// File: rtl/bilin_phase_gen_acc.sv
// 8.8 DDA position register: clear, advance by step, integer field clamped to max_int.
module bilin_phase_acc #(
  parameter int W_CNT  = 12,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [15:0]       step,
  input  logic [W_CNT-1:0]  max_int,
  output logic [W_CNT-1:0]  pos_int,
  output logic [FRAC_W-1:0] pos_frac
);
  localparam int POS_W = W_CNT + FRAC_W;

  logic [POS_W-1:0] pos;
  logic [POS_W:0]   sum;
  logic [POS_W-1:0] pos_nxt;

  // One extra bit on the sum so an overshoot past the last pixel is seen, not wrapped.
  always_comb begin
    sum     = {1'b0, pos} + (POS_W+1)'(step);
    pos_nxt = sum[POS_W-1:0];
    if (sum[POS_W:FRAC_W] > {1'b0, max_int})
      pos_nxt = {max_int, sum[FRAC_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pos <= '0;
    else if (clr) pos <= '0;
    else if (adv) pos <= pos_nxt;
  end

  assign pos_int  = pos[POS_W-1:FRAC_W];
  assign pos_frac = pos[FRAC_W-1:0];
endmodule

// File: rtl/bilin_phase_gen.sv
// Horizontal bilinear front end: walks a 2-pixel window along the input line and
// emits (p[n], p[n+1], frac) for every output pixel.
module bilin_phase_gen
  import bilin_pkg::*;
#(
  parameter int W_CNT  = 12,
  parameter int FRAC_W = bilin_pkg::FRAC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  bilin_phase_gen_if.slave bus
);
  state_t            state;
  logic [15:0]       step_q;
  logic [W_CNT-1:0]  in_w_q, out_w_q;
  logic [W_CNT-1:0]  n, in_cnt, out_cnt;
  logic [7:0]        p0, p1;
  logic [W_CNT-1:0]  pos_int;
  logic [FRAC_W-1:0] pos_frac;
  logic              at_n, need_pix, pix_rdy, take, acc_clr, acc_adv;

  assign at_n     = (pos_int == n);
  assign need_pix = (in_cnt < in_w_q);
  assign acc_clr  = (state == IDLE) && bus.sol_i;
  assign acc_adv  = (state == RUN) && at_n;

  // Ready depends only on registered state, so it never combinationally follows pix_vld_i.
  always_comb begin
    pix_rdy = 1'b0;
    case (state)
      FILL:    pix_rdy = 1'b1;
      RUN:     pix_rdy = !at_n && need_pix;
      DRAIN:   pix_rdy = need_pix;
      default: pix_rdy = 1'b0;
    endcase
  end

  assign take          = pix_rdy && bus.pix_vld_i;
  assign bus.pix_rdy_o = pix_rdy;

  bilin_phase_acc #(.W_CNT(W_CNT), .FRAC_W(FRAC_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .adv      (acc_adv),
    .step     (step_q),
    .max_int  (in_w_q - W_CNT'(1)),
    .pos_int  (pos_int),
    .pos_frac (pos_frac)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      step_q        <= '0;
      in_w_q        <= '0;
      out_w_q       <= '0;
      n             <= '0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      p0            <= '0;
      p1            <= '0;
      bus.din1_o    <= '0;
      bus.din2_o    <= '0;
      bus.kremain_o <= '0;
      bus.out_vld_o <= 1'b0;
      bus.eol_o     <= 1'b0;
      bus.busy_o    <= 1'b0;
    end else begin
      bus.out_vld_o <= 1'b0;
      bus.eol_o     <= 1'b0;
      case (state)
        IDLE: if (bus.sol_i) begin
          step_q     <= bus.step_i;
          in_w_q     <= bus.in_width_i;
          out_w_q    <= bus.out_width_i;
          n          <= '0;
          in_cnt     <= '0;
          out_cnt    <= '0;
          bus.busy_o <= 1'b1;
          state      <= FILL;
        end
        FILL: if (take) begin
          in_cnt <= in_cnt + W_CNT'(1);
          if (in_cnt == '0) p0 <= bus.pix_i;
          else begin
            p1    <= bus.pix_i;
            state <= RUN;
          end
        end
        RUN: if (at_n) begin
          bus.din1_o    <= p0;
          bus.din2_o    <= p1;
          bus.kremain_o <= pos_frac;
          bus.out_vld_o <= 1'b1;
          out_cnt       <= out_cnt + W_CNT'(1);
          if (out_cnt == out_w_q - W_CNT'(1)) begin
            bus.eol_o <= 1'b1;
            if (need_pix) state <= DRAIN;
            else begin
              state      <= IDLE;
              bus.busy_o <= 1'b0;
            end
          end
        end else if (need_pix) begin
          if (take) begin
            p0     <= p1;
            p1     <= bus.pix_i;
            n      <= n + W_CNT'(1);
            in_cnt <= in_cnt + W_CNT'(1);
          end
        end else begin
          // Past the last input pixel: replicate the edge instead of fetching.
          p0 <= p1;
          n  <= n + W_CNT'(1);
        end
        DRAIN: if (!need_pix) begin
          state      <= IDLE;
          bus.busy_o <= 1'b0;
        end else if (take) begin
          in_cnt <= in_cnt + W_CNT'(1);
          if (in_cnt == in_w_q - W_CNT'(1)) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bilin_phase_gen.sv
// Directed-vector bench for bilin_phase_gen with hand-computed output tables.
module tb_bilin_phase_gen;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bilin_phase_gen_if #(.W_CNT(12), .FRAC_W(8)) bus ();
  bilin_phase_gen #(.W_CNT(12), .FRAC_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_cmp = 0, n_err = 0, cyc = 0, acc_cnt = 0;
  logic [23:0] oq[$];
  bit          eq[$];
  int          ocyc[$];
  logic [7:0]  pix_tab[16];
  logic [23:0] ex[16];
  int          nex;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_vld_o) begin
      oq.push_back({bus.din1_o, bus.din2_o, bus.kremain_o});
      eq.push_back(bus.eol_o);
      ocyc.push_back(cyc);
    end
    if (bus.pix_vld_i && bus.pix_rdy_o) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_din1"}, 32'(bus.din1_o), 0);
    chk({tag, "_din2"}, 32'(bus.din2_o), 0);
    chk({tag, "_k"},    32'(bus.kremain_o), 0);
    chk({tag, "_vld"},  32'(bus.out_vld_o), 0);
    chk({tag, "_eol"},  32'(bus.eol_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_rdy"},  32'(bus.pix_rdy_o), 0);
  endtask

  task automatic run_line(input string tag, input logic [15:0] st, input int inw, input int outw,
                          input bit tog, output int lat, output int busy_lag);
    int q0, a0, sol_c, done_c, idx, nout;
    bit took, done;
    q0 = oq.size(); a0 = acc_cnt; done_c = 0;
    @(posedge clk); #1;
    bus.step_i = st; bus.in_width_i = 12'(inw); bus.out_width_i = 12'(outw);
    bus.sol_i = 1'b1; bus.pix_i = pix_tab[0]; bus.pix_vld_i = !tog;
    @(negedge clk); sol_c = cyc;
    @(posedge clk); #1; bus.sol_i = 1'b0;
    idx = 0; done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      bus.pix_i     = (idx < 16) ? pix_tab[idx] : 8'h00;
      bus.pix_vld_i = tog ? c[0] : 1'b1;
      @(negedge clk);
      took = bus.pix_vld_i && bus.pix_rdy_o;
      if (!bus.busy_o) begin done = 1; done_c = cyc; end
      @(posedge clk); #1;
      if (took) idx++;
    end
    bus.pix_vld_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk({tag, "_done"}, 32'(done), 1);
    nout = oq.size() - q0;
    chk({tag, "_nout"}, nout, nex);
    for (int i = 0; i < nex; i++)
      if (q0 + i < oq.size()) begin
        chk($sformatf("%s_pix%0d", tag, i), 32'(oq[q0+i]), 32'(ex[i]));
        chk($sformatf("%s_eol%0d", tag, i), 32'(eq[q0+i]), 32'(i == nex - 1));
      end
    chk({tag, "_accepted"}, acc_cnt - a0, inw);
    chk({tag, "_rdy_idle"}, 32'(bus.pix_rdy_o), 0);
    lat      = (nout > 0) ? ocyc[q0] - sol_c : -1;
    busy_lag = (nout > 0) ? done_c - ocyc[q0+nout-1] : -1;
  endtask

  task automatic set_case1();
    pix_tab[0] = 8'd10; pix_tab[1] = 8'd20; pix_tab[2] = 8'd30; pix_tab[3] = 8'd40;
    nex = 4;
    ex[0] = {8'd10, 8'd20, 8'h00}; ex[1] = {8'd20, 8'd30, 8'h00};
    ex[2] = {8'd30, 8'd40, 8'h00}; ex[3] = {8'd40, 8'd40, 8'h00};
  endtask

  initial begin
    int lat, lag;
    bus.step_i = '0; bus.in_width_i = '0; bus.out_width_i = '0;
    bus.sol_i = 1'b0; bus.pix_i = '0; bus.pix_vld_i = 1'b0;
    for (int i = 0; i < 16; i++) pix_tab[i] = 8'h00;
    #1 rst_n = 1'b0;
    #11 chk_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Unity scale: straight copy with right-edge replication on the last pair.
    set_case1();
    run_line("c1", 16'h0100, 4, 4, 1'b0, lat, lag);
    chk("c1_latency", lat, 4);
    chk("c1_busy_drop", 32'(lag >= 0 && lag <= 1), 1);

    // 2x upscale: each pair used twice, phase alternating 0 / 0.5.
    pix_tab[0] = 8'd0; pix_tab[1] = 8'd100; pix_tab[2] = 8'd200; pix_tab[3] = 8'd50;
    nex = 8;
    ex[0] = {8'd0, 8'd100, 8'h00};   ex[1] = {8'd0, 8'd100, 8'h80};
    ex[2] = {8'd100, 8'd200, 8'h00}; ex[3] = {8'd100, 8'd200, 8'h80};
    ex[4] = {8'd200, 8'd50, 8'h00};  ex[5] = {8'd200, 8'd50, 8'h80};
    ex[6] = {8'd50, 8'd50, 8'h00};   ex[7] = {8'd50, 8'd50, 8'h80};
    run_line("c2", 16'h0080, 4, 8, 1'b0, lat, lag);

    // 1.5 step downscale: window skips p2 as the base pixel.
    pix_tab[0] = 8'd11; pix_tab[1] = 8'd22; pix_tab[2] = 8'd33;
    pix_tab[3] = 8'd44; pix_tab[4] = 8'd55; pix_tab[5] = 8'd66;
    nex = 4;
    ex[0] = {8'd11, 8'd22, 8'h00}; ex[1] = {8'd22, 8'd33, 8'h80};
    ex[2] = {8'd44, 8'd55, 8'h00}; ex[3] = {8'd55, 8'd66, 8'h80};
    run_line("c3", 16'h0180, 6, 4, 1'b0, lat, lag);

    // Input valid toggling every cycle must not change the result.
    set_case1();
    run_line("c4", 16'h0100, 4, 4, 1'b1, lat, lag);

    // Short output line: remaining input drained without output strobes.
    for (int i = 0; i < 8; i++) pix_tab[i] = 8'(i + 1);
    nex = 3;
    ex[0] = {8'd1, 8'd2, 8'h00}; ex[1] = {8'd2, 8'd3, 8'h00}; ex[2] = {8'd3, 8'd4, 8'h00};
    run_line("c5", 16'h0100, 8, 3, 1'b0, lat, lag);

    // Reset in the middle of a line, then a clean rerun of the unity case.
    set_case1();
    @(posedge clk); #1;
    bus.step_i = 16'h0100; bus.in_width_i = 12'd4; bus.out_width_i = 12'd4;
    bus.sol_i = 1'b1; bus.pix_vld_i = 1'b1; bus.pix_i = 8'd10;
    @(posedge clk); #1 bus.sol_i = 1'b0;
    @(posedge clk); #1 bus.pix_i = 8'd20;
    @(posedge clk); #1 bus.pix_i = 8'd30;
    @(posedge clk); #1;
    chk("c6_pre_vld", 32'(bus.out_vld_o), 1);
    chk("c6_pre_pair", {bus.din1_o, bus.din2_o}, {8'd10, 8'd20});
    #2 rst_n = 1'b0;
    #1 chk_zero("c6_rst");
    @(posedge clk); #1 rst_n = 1'b1; bus.pix_vld_i = 1'b0;
    repeat (2) @(posedge clk);
    run_line("c6", 16'h0100, 4, 4, 1'b0, lat, lag);
    chk("c6_latency", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
